// File: rtl/judge_pkg.sv
// Shared definitions for the prompt judge.
//   NUM_COLS   : number of prompt columns.
//   SCORE_W    : default width of the score and combo counters.
//   col_vec_t  : one bit per column.
//   popcount4  : number of set bits in a column vector.
//   sat_add    : SCORE_W-bit add that sticks at all-ones instead of wrapping.
package judge_pkg;

  localparam int NUM_COLS = 4;
  localparam int SCORE_W  = 10;

  typedef logic [NUM_COLS-1:0] col_vec_t;

  function automatic logic [2:0] popcount4(input col_vec_t v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                 input logic [SCORE_W-1:0] b);
    logic [SCORE_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
  endfunction

endpackage

// File: rtl/judge_lane.sv
// One column of the prompt judge: pending flag, scrolling light column,
// key edge detector and the hit/miss decision for the judge row.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   tick       : scroll strobe from the shared divider
//   start      : prompt-start pulse for this column
//   key        : player button for this column (synchronised, level)
//   col        : light column, bit 0 = entry row, bit ROWS-1 = judge row
//   hit_ev     : combinational hit decision for this cycle
//   miss_ev    : combinational miss decision for this cycle
module judge_lane #(
  parameter int ROWS = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            tick,
  input  logic            start,
  input  logic            key,
  output logic [ROWS-1:0] col,
  output logic            hit_ev,
  output logic            miss_ev
);

  logic            pending_reg, pending_next;
  logic [ROWS-1:0] col_reg, col_next;
  logic            key_q_reg;

  logic            press;
  logic            bottom;
  logic            entry;
  logic [ROWS-1:0] col_kept;

  assign press  = key & ~key_q_reg;
  assign bottom = col_reg[ROWS-1];
  // A start in the tick cycle still rides in on that tick.
  assign entry  = pending_reg | start;

  always_comb begin
    hit_ev  = press & bottom;
    // A press that lands on the expiring tick is a hit, never a miss.
    miss_ev = (press & ~bottom) | (tick & ~press & bottom);

    col_kept = col_reg;
    if (hit_ev) begin
      col_kept[ROWS-1] = 1'b0;
    end

    col_next     = col_kept;
    pending_next = entry;
    if (tick) begin
      col_next     = {col_kept[ROWS-2:0], entry};
      pending_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_reg <= 1'b0;
      col_reg     <= '0;
      key_q_reg   <= 1'b0;
    end else begin
      pending_reg <= pending_next;
      col_reg     <= col_next;
      key_q_reg   <= key;
    end
  end

  assign col = col_reg;

endmodule

// File: rtl/prompt_judge.sv
// Prompt judge: scrolls per-column prompts down a column of lights and
// judges the player's presses at the bottom row.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   start[4]   : one-cycle prompt-start pulses, bit i = column i
//   key[4]     : player buttons, synchronised, active-high level
//   lights     : column i at bits [i*ROWS +: ROWS], bit 0 of a column is the top row
//   hit[4]     : registered one-cycle pulse per correct press
//   miss[4]    : registered one-cycle pulse per wrong press or expired prompt
//   score      : saturating hit total
//   combo      : saturating hits since the last miss
// Build option MISS_PENALTY_EN: when defined, each miss subtracts one from
// score (floored at 0); otherwise misses leave score untouched.
module prompt_judge #(
  parameter int ROWS      = 8,
  parameter int SHIFT_DIV = 16,
  parameter int SCORE_W   = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3:0]           start,
  input  logic [3:0]           key,
  output logic [4*ROWS-1:0]    lights,
  output logic [3:0]           hit,
  output logic [3:0]           miss,
  output logic [SCORE_W-1:0]   score,
  output logic [SCORE_W-1:0]   combo
);

  import judge_pkg::*;

  localparam int DIV_W = (SHIFT_DIV > 1) ? $clog2(SHIFT_DIV) : 1;

  logic [DIV_W-1:0]   div_reg, div_next;
  logic               tick;

  col_vec_t           hit_ev, miss_ev;
  col_vec_t           hit_reg, miss_reg;
  logic [2:0]         hit_cnt;

  logic [SCORE_W-1:0] score_reg, score_next;
  logic [SCORE_W-1:0] combo_reg, combo_next;

  // Scroll divider: tick is high for the whole last cycle of each period.
  assign tick = (div_reg == DIV_W'(SHIFT_DIV - 1));

  always_comb begin
    div_next = div_reg + 1'b1;
    if (tick) begin
      div_next = '0;
    end
  end

  for (genvar gi = 0; gi < NUM_COLS; gi++) begin : g_lane
    judge_lane #(
      .ROWS (ROWS)
    ) u_lane (
      .clk     (clk),
      .reset   (reset),
      .tick    (tick),
      .start   (start[gi]),
      .key     (key[gi]),
      .col     (lights[gi*ROWS +: ROWS]),
      .hit_ev  (hit_ev[gi]),
      .miss_ev (miss_ev[gi])
    );
  end

  assign hit_cnt = popcount4(hit_ev);

`ifdef MISS_PENALTY_EN
  localparam int SCORE_MAX = (1 << SCORE_W) - 1;

  logic [2:0] miss_cnt;
  int         penalty_sum;

  assign miss_cnt = popcount4(miss_ev);

  always_comb begin
    penalty_sum = int'(score_reg) + int'(hit_cnt) - int'(miss_cnt);
    if (penalty_sum < 0) begin
      score_next = '0;
    end else if (penalty_sum > SCORE_MAX) begin
      score_next = '1;
    end else begin
      score_next = penalty_sum[SCORE_W-1:0];
    end
  end
`else
  always_comb begin
    score_next = sat_add(score_reg, SCORE_W'(hit_cnt));
  end
`endif

  // Any miss in the cycle breaks the combo, even alongside hits.
  always_comb begin
    combo_next = sat_add(combo_reg, SCORE_W'(hit_cnt));
    if (|miss_ev) begin
      combo_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_reg   <= '0;
      hit_reg   <= '0;
      miss_reg  <= '0;
      score_reg <= '0;
      combo_reg <= '0;
    end else begin
      div_reg   <= div_next;
      hit_reg   <= hit_ev;
      miss_reg  <= miss_ev;
      score_reg <= score_next;
      combo_reg <= combo_next;
    end
  end

  assign hit   = hit_reg;
  assign miss  = miss_reg;
  assign score = score_reg;
  assign combo = combo_reg;

endmodule

// File: tb/tb_prompt_judge.sv
// Directed bench for prompt_judge (ROWS=8, SHIFT_DIV=16, SCORE_W=10).
// The bench counts clock edges since reset release; with SHIFT_DIV=16 the
// scrolling tick is applied on every edge whose count is a multiple of 16.
module tb_prompt_judge;

  localparam int ROWS = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [3:0]        start;
  logic [3:0]        key;
  logic [4*ROWS-1:0] lights;
  logic [3:0]        hit;
  logic [3:0]        miss;
  logic [9:0]        score;
  logic [9:0]        combo;

  int checks = 0;
  int errors = 0;
  int edges  = 0;
  int exp_score = 0;
  int exp_combo = 0;

  prompt_judge #(
    .ROWS      (8),
    .SHIFT_DIV (16),
    .SCORE_W   (10)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .key    (key),
    .lights (lights),
    .hit    (hit),
    .miss   (miss),
    .score  (score),
    .combo  (combo)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  function automatic int score_after(int cur, int h, int m);
    int s;
`ifdef MISS_PENALTY_EN
    s = cur + h - m;
    if (s < 0) s = 0;
`else
    s = cur + h;
`endif
    if (s > 1023) s = 1023;
    return s;
  endfunction

  task automatic step();
    @(posedge clk);
    if (reset) edges = 0;
    else edges++;
    #1;
  endtask

  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Advance until n more tick edges have been applied; returns just after the last.
  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      do step(); while (edges % 16 != 0);
    end
  endtask

  // Advance so that the next edge is a tick edge.
  task automatic to_pre_tick();
    while (edges % 16 != 15) step();
  endtask

  // Drive a one-cycle start pulse on a non-tick edge.
  task automatic pulse_start(input logic [3:0] s);
    if (edges % 16 == 15) step();
    start = s;
    step();
    start = 4'b0000;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 4'b0; key = 4'b0;
    step_n(3);
    reset = 1'b0;
    if (lights !== 32'h0) begin errors++; $display("FAIL reset_lights got %h want %h", lights, 32'h0); end
    checks++;
    if (hit !== 4'b0) begin errors++; $display("FAIL reset_hit got %b want 0000", hit); end
    checks++;
    if (miss !== 4'b0) begin errors++; $display("FAIL reset_miss got %b want 0000", miss); end
    checks++;
    if (score !== 10'd0) begin errors++; $display("FAIL reset_score got %0d want 0", score); end
    checks++;
    if (combo !== 10'd0) begin errors++; $display("FAIL reset_combo got %0d want 0", combo); end
    checks++;
    $display("reset: lights=%h hit=%b miss=%b score=%0d combo=%0d", lights, hit, miss, score, combo);
  endtask

  task automatic test_scroll_hit();
    step_n(2);
    start = 4'b0001;
    step();
    start = 4'b0000;
    wait_ticks(1);
    if (lights !== 32'h0000_0001) begin errors++; $display("FAIL entry_row got %h want %h", lights, 32'h1); end
    checks++;
    wait_ticks(7);
    if (lights !== 32'h0000_0080) begin errors++; $display("FAIL judge_row got %h want %h", lights, 32'h80); end
    checks++;
    step_n(2);
    key = 4'b0001;
    step();
    exp_score = score_after(exp_score, 1, 0); exp_combo = exp_combo + 1;
    if (hit !== 4'b0001) begin errors++; $display("FAIL hit0 got %b want 0001", hit); end
    checks++;
    if (score !== 10'(exp_score)) begin errors++; $display("FAIL hit0_score got %0d want %0d", score, exp_score); end
    checks++;
    if (combo !== 10'(exp_combo)) begin errors++; $display("FAIL hit0_combo got %0d want %0d", combo, exp_combo); end
    checks++;
    if (lights !== 32'h0) begin errors++; $display("FAIL hit0_clear got %h want 0", lights); end
    checks++;
    step();
    if (hit !== 4'b0000) begin errors++; $display("FAIL hit0_pulse_once got %b want 0000", hit); end
    checks++;
    key = 4'b0000;
    step();
    $display("scroll_hit: score=%0d combo=%0d", score, combo);
  endtask

  task automatic test_expire();
    pulse_start(4'b0001);
    wait_ticks(8);
    if (lights !== 32'h0000_0080 || miss !== 4'b0) begin
      errors++; $display("FAIL expire_pre got lights=%h miss=%b want 80 0000", lights, miss);
    end
    checks++;
    wait_ticks(1);
    exp_score = score_after(exp_score, 0, 1); exp_combo = 0;
    if (miss !== 4'b0001 || hit !== 4'b0000) begin
      errors++; $display("FAIL expire_miss got miss=%b hit=%b want 0001 0000", miss, hit);
    end
    checks++;
    if (score !== 10'(exp_score) || combo !== 10'(exp_combo)) begin
      errors++; $display("FAIL expire_counts got %0d/%0d want %0d/%0d", score, combo, exp_score, exp_combo);
    end
    checks++;
    if (lights !== 32'h0) begin errors++; $display("FAIL expire_clear got %h want 0", lights); end
    checks++;
    step();
    if (miss !== 4'b0000) begin errors++; $display("FAIL expire_pulse_once got %b want 0000", miss); end
    checks++;
    $display("expire: score=%0d combo=%0d", score, combo);
  endtask

  task automatic test_false_press();
    pulse_start(4'b1011);
    wait_ticks(8);
    key = 4'b1011;
    step();
    exp_score = score_after(exp_score, 3, 0); exp_combo = exp_combo + 3;
    if (hit !== 4'b1011 || combo !== 10'(exp_combo) || score !== 10'(exp_score)) begin
      errors++; $display("FAIL triple_hit got hit=%b combo=%0d score=%0d want 1011 %0d %0d",
                         hit, combo, score, exp_combo, exp_score);
    end
    checks++;
    key = 4'b0000;
    step();
    key = 4'b0100;
    step();
    exp_score = score_after(exp_score, 0, 1); exp_combo = 0;
    if (miss !== 4'b0100 || hit !== 4'b0000) begin
      errors++; $display("FAIL false_press got miss=%b hit=%b want 0100 0000", miss, hit);
    end
    checks++;
    if (combo !== 10'(exp_combo) || score !== 10'(exp_score)) begin
      errors++; $display("FAIL false_press_counts got %0d/%0d want %0d/%0d", score, combo, exp_score, exp_combo);
    end
    checks++;
    for (int i = 0; i < 40; i++) begin
      step();
      if (hit !== 4'b0 || miss !== 4'b0) begin
        errors++; $display("FAIL held_key cycle %0d got hit=%b miss=%b want 0000 0000", i, hit, miss);
      end
      checks++;
    end
    key = 4'b0000;
    step();
    $display("false_press: score=%0d combo=%0d", score, combo);
  endtask

  task automatic test_dual();
    pulse_start(4'b1001);
    wait_ticks(8);
    key = 4'b1001;
    step();
    exp_score = score_after(exp_score, 2, 0); exp_combo = exp_combo + 2;
    if (hit !== 4'b1001 || miss !== 4'b0000) begin
      errors++; $display("FAIL dual_hit got hit=%b miss=%b want 1001 0000", hit, miss);
    end
    checks++;
    if (score !== 10'(exp_score) || combo !== 10'(exp_combo)) begin
      errors++; $display("FAIL dual_counts got %0d/%0d want %0d/%0d", score, combo, exp_score, exp_combo);
    end
    checks++;
    key = 4'b0000;
    step();
    pulse_start(4'b1001);
    wait_ticks(8);
    key = 4'b1011;
    step();
    exp_score = score_after(exp_score, 2, 1); exp_combo = 0;
    if (hit !== 4'b1001 || miss !== 4'b0010) begin
      errors++; $display("FAIL dual_mixed got hit=%b miss=%b want 1001 0010", hit, miss);
    end
    checks++;
    if (score !== 10'(exp_score) || combo !== 10'(exp_combo)) begin
      errors++; $display("FAIL dual_mixed_counts got %0d/%0d want %0d/%0d", score, combo, exp_score, exp_combo);
    end
    checks++;
    key = 4'b0000;
    step();
    $display("dual: score=%0d combo=%0d", score, combo);
  endtask

  task automatic test_coincide();
    pulse_start(4'b0001);
    wait_ticks(8);
    to_pre_tick();
    key = 4'b0001;
    step();
    exp_score = score_after(exp_score, 1, 0); exp_combo = exp_combo + 1;
    if (hit !== 4'b0001 || miss !== 4'b0000) begin
      errors++; $display("FAIL press_on_expiry got hit=%b miss=%b want 0001 0000", hit, miss);
    end
    checks++;
    if (score !== 10'(exp_score) || combo !== 10'(exp_combo) || lights !== 32'h0) begin
      errors++; $display("FAIL press_on_expiry_state got %0d/%0d lights=%h want %0d/%0d 0",
                         score, combo, lights, exp_score, exp_combo);
    end
    checks++;
    key = 4'b0000;
    to_pre_tick();
    start = 4'b0100;
    step();
    start = 4'b0000;
    if (lights !== 32'h0001_0000) begin
      errors++; $display("FAIL start_on_tick got %h want %h", lights, 32'h0001_0000);
    end
    checks++;
    step();
    $display("coincide: score=%0d combo=%0d", score, combo);
  endtask

  task automatic test_reset_midgame();
    pulse_start(4'b0111);
    wait_ticks(3);
    // Column 2 also carries the prompt entered in the previous test.
    if (lights !== 32'h000C_0404) begin
      errors++; $display("FAIL in_flight got %h want %h", lights, 32'h000C_0404);
    end
    checks++;
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_score = 0; exp_combo = 0;
    if (lights !== 32'h0 || hit !== 4'b0 || miss !== 4'b0) begin
      errors++; $display("FAIL midgame_reset got lights=%h hit=%b miss=%b want 0", lights, hit, miss);
    end
    checks++;
    if (score !== 10'd0 || combo !== 10'd0) begin
      errors++; $display("FAIL midgame_reset_counts got %0d/%0d want 0/0", score, combo);
    end
    checks++;
    step();
    if (lights !== 32'h0 || hit !== 4'b0 || miss !== 4'b0) begin
      errors++; $display("FAIL after_reset got lights=%h hit=%b miss=%b want 0", lights, hit, miss);
    end
    checks++;
    $display("reset_midgame: lights=%h score=%0d combo=%0d", lights, score, combo);
  endtask

  task automatic test_penalty();
    pulse_start(4'b0001);
    wait_ticks(8);
    key = 4'b0001;
    step();
    exp_score = score_after(exp_score, 1, 0); exp_combo = exp_combo + 1;
    if (score !== 10'(exp_score)) begin errors++; $display("FAIL penalty_setup got %0d want %0d", score, exp_score); end
    checks++;
    key = 4'b0000;
    step();
    key = 4'b0110;
    step();
    exp_score = score_after(exp_score, 0, 2); exp_combo = 0;
    if (miss !== 4'b0110) begin errors++; $display("FAIL penalty_miss got %b want 0110", miss); end
    checks++;
    if (score !== 10'(exp_score) || combo !== 10'(exp_combo)) begin
      errors++; $display("FAIL penalty_score got %0d/%0d want %0d/%0d", score, combo, exp_score, exp_combo);
    end
    checks++;
    key = 4'b0000;
    step();
    $display("penalty: score=%0d combo=%0d", score, combo);
  endtask

  initial begin
    test_reset();
    test_scroll_hit();
    test_expire();
    test_false_press();
    test_dual();
    test_coincide();
    test_reset_midgame();
    test_penalty();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
